// File: rtl/spi_transaction_controller.sv
// rtl/spi_transaction_controller.sv - SPI slave transaction sequencer: address/rw byte, then one data byte read or write.
module spi_transaction_controller #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  csN,
    input  logic                  sclkPosEdge,
    input  logic                  sclkNegEdge,
    input  logic [DATA_WIDTH-1:0] shiftRegOut,
    output logic                  srShiftEn,
    output logic                  srParallelLoad,
    output logic                  addrWe,
    output logic                  dmWe,
    output logic                  misoBufe,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        DECIDE,
        READ_WAIT,
        READ_LOAD,
        READ_SHIFT,
        WRITE_SHIFT,
        WRITE_COMMIT,
        DONE
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(DATA_WIDTH - 1);

    state_t                 state;
    logic [COUNT_WIDTH-1:0] bitCount;
    logic                   posEdge;
    logic                   negEdge;
    logic                   lastPos;
    logic                   live;
    logic                   unusedAddrBits;

    // A coincident rising and falling strobe counts as a rising edge only.
    assign posEdge        = sclkPosEdge;
    assign negEdge        = sclkNegEdge & ~sclkPosEdge;
    assign lastPos        = posEdge && (bitCount == LAST_BIT);
    assign live           = ~csN;
    assign unusedAddrBits = ^shiftRegOut[DATA_WIDTH-1:1];

    always_comb begin
        srShiftEn      = 1'b0;
        srParallelLoad = 1'b0;
        addrWe         = 1'b0;
        dmWe           = 1'b0;
        misoBufe       = 1'b0;
        busy           = (state != IDLE);
        case (state)
            GET_ADDR:     srShiftEn = posEdge & live;
            DECIDE:       addrWe = live;
            READ_LOAD:    srParallelLoad = live;
            READ_SHIFT: begin
                misoBufe  = live;
                // The falling edge ahead of the first data rising edge must not shift out the MSB.
                srShiftEn = negEdge & live & (bitCount != '0);
            end
            WRITE_SHIFT:  srShiftEn = posEdge & live;
            WRITE_COMMIT: dmWe = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state    <= IDLE;
            bitCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (live) begin
                        state    <= GET_ADDR;
                        bitCount <= '0;
                    end
                end
                GET_ADDR: begin
                    if (csN) begin
                        state <= IDLE;
                    end else if (lastPos) begin
                        state    <= DECIDE;
                        bitCount <= '0;
                    end else if (posEdge) begin
                        bitCount <= bitCount + 1'b1;
                    end
                end
                DECIDE: begin
                    bitCount <= '0;
                    if (csN)                 state <= IDLE;
                    else if (shiftRegOut[0]) state <= READ_WAIT;
                    else                     state <= WRITE_SHIFT;
                end
                READ_WAIT: state <= csN ? IDLE : READ_LOAD;
                READ_LOAD: state <= csN ? IDLE : READ_SHIFT;
                READ_SHIFT, WRITE_SHIFT: begin
                    if (csN) begin
                        state <= IDLE;
                    end else if (lastPos) begin
                        state    <= (state == READ_SHIFT) ? DONE : WRITE_COMMIT;
                        bitCount <= '0;
                    end else if (posEdge) begin
                        bitCount <= bitCount + 1'b1;
                    end
                end
                WRITE_COMMIT: state <= DONE;
                DONE: begin
                    if (csN) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_transaction_controller.sv
// tb/tb_spi_transaction_controller.sv - randomized SPI transactions checked against a bit-count timeline model.
module tb_spi_transaction_controller;

    logic       clk = 1'b0;
    logic       resetN;
    logic       csN;
    logic       sclkPosEdge;
    logic       sclkNegEdge;
    logic [7:0] shiftRegOut;
    logic       srShiftEn;
    logic       srParallelLoad;
    logic       addrWe;
    logic       dmWe;
    logic       misoBufe;
    logic       busy;

    int nTests = 0;
    int nFail  = 0;

    logic       checkEn = 1'b0;
    logic       mosi = 1'b0;
    logic [7:0] curAddr = 8'h00;
    logic [7:0] curData = 8'h00;
    logic [7:0] curLoad = 8'h00;
    logic [7:0] sr = 8'h00;

    int cntShift, cntAddr, cntLoad, cntDm, cntMiso;

    spi_transaction_controller #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .csN            (csN),
        .sclkPosEdge    (sclkPosEdge),
        .sclkNegEdge    (sclkNegEdge),
        .shiftRegOut    (shiftRegOut),
        .srShiftEn      (srShiftEn),
        .srParallelLoad (srParallelLoad),
        .addrWe         (addrWe),
        .dmWe           (dmWe),
        .misoBufe       (misoBufe),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Peripheral shift register driven by the controller's strobes.
    always @(posedge clk) begin
        if (srParallelLoad)  sr <= curLoad;
        else if (srShiftEn)  sr <= {sr[6:0], mosi};
    end
    assign shiftRegOut = sr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position in the transaction given by rising edges counted and cycles since the address byte ended.
    initial begin
        bit mBusy = 0, mDone = 0, mCommit = 0, mRw = 0;
        int mPos = 0, mK = 0, kPrev;
        logic pe, ne, live;
        logic eShift, eLoad, eAddr, eDm, eMiso, eBusy;
        forever begin
            @(negedge clk);
            if (checkEn) begin
                pe = sclkPosEdge; ne = sclkNegEdge & ~pe; live = ~csN;
                eShift = 0; eLoad = 0; eAddr = 0; eDm = 0; eMiso = 0; eBusy = mBusy;
                if (mBusy) begin
                    if (mDone)          eDm = mCommit;
                    else if (mPos < 8)  eShift = pe & live;
                    else if (mK == 1)   eAddr = live;
                    else if (mRw) begin
                        if (mK == 3) eLoad = live;
                        else if (mK >= 4) begin
                            eMiso  = live;
                            eShift = ne & live & (mPos >= 9);
                        end
                    end else eShift = pe & live;
                end
                check("srShiftEn", srShiftEn, eShift);
                check("srParallelLoad", srParallelLoad, eLoad);
                check("addrWe", addrWe, eAddr);
                check("dmWe", dmWe, eDm);
                check("misoBufe", misoBufe, eMiso);
                check("busy", busy, eBusy);
                if (dmWe) check("dm_data", shiftRegOut, curData);
                cntShift += srShiftEn; cntAddr += addrWe; cntLoad += srParallelLoad;
                cntDm += dmWe; cntMiso += misoBufe;

                if (!resetN) mBusy = 0;
                else if (!mBusy) begin
                    if (live) begin
                        mBusy = 1; mPos = 0; mK = 0; mDone = 0; mCommit = 0; mRw = curAddr[0];
                    end
                end else if (mDone) begin
                    if (mCommit) mCommit = 0;
                    else if (!live) mBusy = 0;
                end else if (!live) mBusy = 0;
                else begin
                    kPrev = mK;
                    if (mPos >= 8) mK++;
                    if (mPos < 8) begin
                        if (pe) begin
                            mPos++;
                            if (mPos == 8) mK = 1;
                        end
                    end else if (pe && ((!mRw && kPrev >= 2) || (mRw && kPrev >= 4))) begin
                        mPos++;
                        if (mPos == 16) begin
                            mDone = 1; mCommit = !mRw;
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input logic cs, input logic p, input logic n);
        csN = cs; sclkPosEdge = p; sclkNegEdge = n;
        @(posedge clk); #1;
    endtask

    task automatic sclkPeriod(input logic b, input int hp);
        mosi = b;
        repeat (hp - 1) cyc(0, 0, 0);
        cyc(0, 1, 0);
        repeat (hp - 1) cyc(0, 0, 0);
        cyc(0, 0, 1);
    endtask

    task automatic xfer(input logic [7:0] a, input logic [7:0] d, input int nBits, input int hp,
                        input int extra, input int gap, input bit rstEnd);
        logic [15:0] frame;
        frame = {a, d};
        curAddr = a; curData = d; curLoad = 8'($urandom);
        cntShift = 0; cntAddr = 0; cntLoad = 0; cntDm = 0; cntMiso = 0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < nBits; i++) sclkPeriod(frame[15-i], hp);
        for (int i = 0; i < extra; i++) sclkPeriod(1'($urandom), hp);
        cyc(0, 0, 0);
        if (rstEnd) begin
            resetN = 0;
            cyc(0, 0, 0);
            resetN = 1;
        end
        repeat (gap) cyc(1, 0, 0);
    endtask

    task automatic checkCounts(input string tag, input int eShift, input int eAddr, input int eLoad,
                               input int eDm, input bit misoExpected);
        check({tag, "_shifts"}, cntShift, eShift);
        check({tag, "_addrWe"}, cntAddr, eAddr);
        check({tag, "_loads"}, cntLoad, eLoad);
        check({tag, "_dmWe"}, cntDm, eDm);
        check({tag, "_miso"}, (cntMiso != 0), misoExpected);
    endtask

    initial begin
        logic [7:0] a, d;
        int nb;
        resetN = 0; csN = 1; sclkPosEdge = 0; sclkNegEdge = 0;
        @(posedge clk); #1;
        checkEn = 1;
        repeat (2) cyc(1, 0, 0);
        resetN = 1;
        repeat (3) cyc(1, 0, 0);

        xfer(8'h54, 8'hC3, 16, 4, 0, 2, 0);
        checkCounts("write", 16, 1, 0, 1, 0);
        xfer(8'h55, 8'h00, 16, 5, 0, 2, 0);
        checkCounts("read", 15, 1, 1, 0, 1);
        xfer(8'h54, 8'h3E, 12, 4, 0, 2, 0);
        checkCounts("abort", 12, 1, 0, 0, 0);
        xfer(8'h55, 8'h00, 11, 4, 0, 2, 1);
        checkCounts("rst_read", 11, 1, 1, 0, 1);
        xfer(8'h54, 8'hA5, 16, 6, 0, 2, 0);
        checkCounts("post_rst_write", 16, 1, 0, 1, 0);
        xfer(8'h54, 8'h5A, 16, 4, 3, 2, 0);
        checkCounts("extra_clk", 16, 1, 0, 1, 0);
        xfer(8'h54, 8'h81, 16, 4, 0, 1, 0);
        checkCounts("b2b_write", 16, 1, 0, 1, 0);
        xfer(8'h55, 8'h00, 16, 4, 0, 2, 0);
        checkCounts("b2b_read", 15, 1, 1, 0, 1);

        for (int t = 0; t < 30; t++) begin
            a  = 8'($urandom);
            d  = 8'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
            xfer(a, d, nb, $urandom_range(4, 7), $urandom_range(0, 2), $urandom_range(1, 3), 0);
            if (nb == 16) begin
                if (a[0]) checkCounts("rand_read", 15, 1, 1, 0, 1);
                else      checkCounts("rand_write", 16, 1, 0, 1, 0);
            end
        end

        repeat (4) cyc(1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/spi_transaction_controller.md
SPI_TRANSACTION_CONTROLLER -- requirements
Module: spi_transaction_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per SPI byte and width of shift-register parallel data.
REQ-002 SHALL have parameter COUNT_WIDTH, default 4, meaning width of internal bit counter; must hold DATA_WIDTH.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port resetN  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port csN  input  1  conditioned chip select, active-low.
REQ-006 SHALL have port sclkPosEdge  input  1  one-clk pulse per conditioned SCLK rising edge.
REQ-007 SHALL have port sclkNegEdge  input  1  one-clk pulse per conditioned SCLK falling edge.
REQ-008 SHALL have port shiftRegOut  input  DATA_WIDTH  shift register parallelDataOut.
REQ-009 SHALL have port srShiftEn  output  1  drives shift register peripheralClkEdge.
REQ-010 SHALL have port srParallelLoad  output  1  drives shift register parallelLoad.
REQ-011 SHALL have port addrWe  output  1  address latch write enable.
REQ-012 SHALL have port dmWe  output  1  data memory write enable.
REQ-013 SHALL have port misoBufe  output  1  MISO tristate buffer enable.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, GET_ADDR, DECIDE, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, DONE; registered state, outputs decoded from state and current-cycle strobes.
REQ-016 SHALL define first byte as address (bits [DATA_WIDTH-1:1]) plus rw in bit 0; rw=1 read, rw=0 write; bits MSB first.
REQ-017 IDLE: all outputs 0; csN low -> GET_ADDR, bitCount cleared to 0.
REQ-018 GET_ADDR: srShiftEn = sclkPosEdge; bitCount +1 per sclkPosEdge; cycle where bitCount==DATA_WIDTH-1 and sclkPosEdge high -> DECIDE.
REQ-019 DECIDE: exactly one cycle; addrWe=1; shiftRegOut[0]=1 -> READ_WAIT, else -> WRITE_SHIFT; bitCount cleared.
REQ-020 READ_WAIT: one cycle, outputs 0 (memory read latency) -> READ_LOAD.
REQ-021 READ_LOAD: one cycle; srParallelLoad=1, srShiftEn=0 -> READ_SHIFT.
REQ-022 READ_SHIFT: misoBufe=1; bitCount +1 per sclkPosEdge; srShiftEn = sclkNegEdge only when 1 <= bitCount <= DATA_WIDTH-1 (negedge before first data posedge ignored); cycle with bitCount==DATA_WIDTH-1 and sclkPosEdge -> DONE.
REQ-023 WRITE_SHIFT: srShiftEn = sclkPosEdge; bitCount +1 per sclkPosEdge; DATA_WIDTH-th posedge -> WRITE_COMMIT.
REQ-024 WRITE_COMMIT: one cycle; dmWe=1 (shift register already updated) -> DONE; completes even if csN high that cycle, then -> IDLE.
REQ-025 DONE: all outputs 0 except busy; further SCLK strobes ignored; csN high -> IDLE.
REQ-026 csN high in GET_ADDR, DECIDE, READ_WAIT, READ_LOAD, READ_SHIFT or WRITE_SHIFT SHALL abort: srShiftEn, srParallelLoad, misoBufe, addrWe forced 0 that cycle; next state IDLE; no dmWe.
REQ-027 sclkPosEdge and sclkNegEdge high same cycle SHALL be treated as sclkPosEdge only.
REQ-028 bitCount SHALL never exceed DATA_WIDTH-1; no wrap within a phase.
REQ-029 SCLK half-period SHALL be at least 4 clk cycles; behaviour below this is unspecified.

Reset
REQ-030 resetN low at rising clk SHALL force state IDLE, bitCount 0, all outputs 0 next cycle, overriding any transaction in progress.
REQ-031 First transaction after resetN release SHALL start only on csN low observed in IDLE.

Verification
REQ-032 Write: csN low, shift 0x54 (addr 0x2A, rw=0) then 0xC3 -> 8 srShiftEn pulses, one addrWe cycle, 8 srShiftEn pulses, dmWe exactly one cycle, shiftRegOut=0xC3 at dmWe, misoBufe never 1.
REQ-033 Read: shift 0x55 (addr 0x2A, rw=1) -> addrWe one cycle, srParallelLoad one cycle two clks later, misoBufe high from READ_SHIFT until DONE, exactly 7 srShiftEn pulses, dmWe never 1.
REQ-034 Abort: csN high after 12 posedges of a write -> IDLE next cycle, dmWe never asserted, busy 0.
REQ-035 Reset mid-read: resetN low one cycle in READ_SHIFT -> all outputs 0 next cycle, state IDLE; subsequent write of 0xA5 completes per REQ-032.
REQ-036 Extra clocks: 3 SCLK periods in DONE -> no srShiftEn/dmWe/misoBufe; csN high -> IDLE.
REQ-037 Back-to-back: write then read separated by csN high for 1 clk -> both complete with correct strobe counts.
